// File: rtl/mips_pkg.sv
// Shared MIPS control encodings: ALUOp classes, R-type funct codes, ALU_Control selects,
// and the multiply/divide engine state type.
package mips_pkg;

    localparam int unsigned ALUOP_W = 2;
    localparam int unsigned FUNCT_W = 6;
    localparam int unsigned ALUCTL_W = 4;

    localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 2'b00;
    localparam logic [ALUOP_W-1:0] ALUOP_SUB   = 2'b01;
    localparam logic [ALUOP_W-1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [ALUOP_W-1:0] ALUOP_IMM   = 2'b11;

    localparam logic [FUNCT_W-1:0] FN_SLL   = 6'b000000;
    localparam logic [FUNCT_W-1:0] FN_SRL   = 6'b000010;
    localparam logic [FUNCT_W-1:0] FN_SRA   = 6'b000011;
    localparam logic [FUNCT_W-1:0] FN_MFHI  = 6'b010000;
    localparam logic [FUNCT_W-1:0] FN_MFLO  = 6'b010010;
    localparam logic [FUNCT_W-1:0] FN_MULT  = 6'b011000;
    localparam logic [FUNCT_W-1:0] FN_MULTU = 6'b011001;
    localparam logic [FUNCT_W-1:0] FN_DIV   = 6'b011010;
    localparam logic [FUNCT_W-1:0] FN_DIVU  = 6'b011011;
    localparam logic [FUNCT_W-1:0] FN_ADD   = 6'b100000;
    localparam logic [FUNCT_W-1:0] FN_SUB   = 6'b100010;
    localparam logic [FUNCT_W-1:0] FN_AND   = 6'b100100;
    localparam logic [FUNCT_W-1:0] FN_OR    = 6'b100101;
    localparam logic [FUNCT_W-1:0] FN_XOR   = 6'b100110;
    localparam logic [FUNCT_W-1:0] FN_NOR   = 6'b100111;
    localparam logic [FUNCT_W-1:0] FN_SLT   = 6'b101010;

    localparam logic [ALUCTL_W-1:0] ALU_AND = 4'b0000;
    localparam logic [ALUCTL_W-1:0] ALU_OR  = 4'b0001;
    localparam logic [ALUCTL_W-1:0] ALU_ADD = 4'b0010;
    localparam logic [ALUCTL_W-1:0] ALU_XOR = 4'b0100;
    localparam logic [ALUCTL_W-1:0] ALU_MUL = 4'b0101;
    localparam logic [ALUCTL_W-1:0] ALU_SUB = 4'b0110;
    localparam logic [ALUCTL_W-1:0] ALU_SLT = 4'b0111;
    localparam logic [ALUCTL_W-1:0] ALU_SLL = 4'b1000;
    localparam logic [ALUCTL_W-1:0] ALU_SRL = 4'b1001;
    localparam logic [ALUCTL_W-1:0] ALU_SRA = 4'b1010;
    localparam logic [ALUCTL_W-1:0] ALU_DIV = 4'b1011;
    localparam logic [ALUCTL_W-1:0] ALU_NOR = 4'b1100;

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} md_state_t;

endpackage

// File: rtl/mdu_iter.sv
// Iterative multiply/divide engine: one bit per cycle on operand magnitudes,
// sign fix-up in the final FIX cycle where the result is presented for one cycle.
module mdu_iter
    import mips_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             flush,
    input  logic             is_div,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done_c,
    output logic [WIDTH-1:0] hi_c,
    output logic [WIDTH-1:0] lo_c
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam int unsigned PW = 2 * WIDTH;

    md_state_t      state;
    logic [CW-1:0]  cnt;
    logic [WIDTH-1:0] acc, lo_q, opb;
    logic           neg_a, neg_b, op_div;

    logic             a_neg, b_neg, last;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   mul_sum, div_shift, div_diff;
    logic [PW-1:0]    prod, prod_neg;

    assign a_neg = is_signed & a[WIDTH-1];
    assign b_neg = is_signed & b[WIDTH-1];
    assign a_mag = a_neg ? WIDTH'(~a + 1'b1) : a;
    assign b_mag = b_neg ? WIDTH'(~b + 1'b1) : b;
    assign last  = (cnt == CW'(WIDTH - 1));

    // Multiply: {acc,lo_q} is the shifting product; divide: acc is the partial remainder
    assign mul_sum   = {1'b0, acc} + {1'b0, (lo_q[0] ? opb : '0)};
    assign div_shift = {acc, lo_q[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, opb};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            busy   <= 1'b0;
            cnt    <= '0;
            acc    <= '0;
            lo_q   <= '0;
            opb    <= '0;
            neg_a  <= 1'b0;
            neg_b  <= 1'b0;
            op_div <= 1'b0;
        end else if (flush) begin
            state <= IDLE;
            busy  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state  <= is_div ? DIV : MUL;
                        busy   <= 1'b1;
                        cnt    <= '0;
                        acc    <= '0;
                        lo_q   <= a_mag;
                        opb    <= b_mag;
                        neg_a  <= a_neg;
                        neg_b  <= b_neg;
                        op_div <= is_div;
                    end
                end
                MUL: begin
                    {acc, lo_q} <= {mul_sum, lo_q[WIDTH-1:1]};
                    cnt <= cnt + 1'b1;
                    if (last) state <= FIX;
                end
                DIV: begin
                    if (!div_diff[WIDTH]) begin
                        acc  <= div_diff[WIDTH-1:0];
                        lo_q <= {lo_q[WIDTH-2:0], 1'b1};
                    end else begin
                        acc  <= div_shift[WIDTH-1:0];
                        lo_q <= {lo_q[WIDTH-2:0], 1'b0};
                    end
                    cnt <= cnt + 1'b1;
                    if (last) state <= FIX;
                end
                FIX: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign prod     = {acc, lo_q};
    assign prod_neg = PW'(~prod + 1'b1);
    assign done_c   = (state == FIX);

    // Divide by zero keeps LO all ones regardless of operand signs
    always_comb begin
        hi_c = '0;
        lo_c = '0;
        if (op_div) begin
            hi_c = neg_a ? WIDTH'(~acc + 1'b1) : acc;
            if (opb == '0)
                lo_c = '1;
            else
                lo_c = (neg_a ^ neg_b) ? WIDTH'(~lo_q + 1'b1) : lo_q;
        end else begin
            {hi_c, lo_c} = (neg_a ^ neg_b) ? prod_neg : prod;
        end
    end

endmodule

// File: rtl/alu_ctrl_mdu.sv
// ALU control decoder with an attached HI/LO multiply/divide unit and its hazard stall.
module alu_ctrl_mdu
    import mips_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_in,
    input  logic [1:0]       ALUOp,
    input  logic [5:0]       Function,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    input  logic             flush,
    output logic [3:0]       ALU_Control,
    output logic             md_busy,
    output logic             stall,
    output logic [WIDTH-1:0] hilo_rdata
);

    logic [WIDTH-1:0] hi, lo, res_hi_c, res_lo_c;
    logic rtype, is_md, is_mf, is_div, is_signed, start, done_c;

    always_comb begin
        ALU_Control = ALU_AND;
        case (ALUOp)
            ALUOP_ADD: ALU_Control = ALU_ADD;
            ALUOP_SUB: ALU_Control = ALU_SUB;
            ALUOP_RTYPE: begin
                case (Function)
                    FN_OR:              ALU_Control = ALU_OR;
                    FN_ADD:             ALU_Control = ALU_ADD;
                    FN_SUB:             ALU_Control = ALU_SUB;
                    FN_NOR:             ALU_Control = ALU_NOR;
                    FN_SLT:             ALU_Control = ALU_SLT;
                    FN_XOR:             ALU_Control = ALU_XOR;
                    FN_MULT, FN_MULTU:  ALU_Control = ALU_MUL;
                    FN_DIV, FN_DIVU:    ALU_Control = ALU_DIV;
                    FN_SLL:             ALU_Control = ALU_SLL;
                    FN_SRL:             ALU_Control = ALU_SRL;
                    FN_SRA:             ALU_Control = ALU_SRA;
                    default:            ALU_Control = ALU_AND;
                endcase
            end
            default: ALU_Control = ALU_AND;
        endcase
    end

    assign rtype     = (ALUOp == ALUOP_RTYPE);
    assign is_md     = rtype && (Function == FN_MULT || Function == FN_MULTU ||
                                 Function == FN_DIV  || Function == FN_DIVU);
    assign is_mf     = rtype && (Function == FN_MFHI || Function == FN_MFLO);
    assign is_div    = (Function == FN_DIV) || (Function == FN_DIVU);
    assign is_signed = (Function == FN_MULT) || (Function == FN_DIV);

    assign stall = valid_in && md_busy && (is_md || is_mf);
    assign start = valid_in && is_md && !stall && !flush;

    // Reads always return committed HI/LO; in-flight results are never forwarded
    always_comb begin
        hilo_rdata = '0;
        if (rtype && Function == FN_MFHI)      hilo_rdata = hi;
        else if (rtype && Function == FN_MFLO) hilo_rdata = lo;
    end

    mdu_iter #(.WIDTH(WIDTH)) u_iter (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .flush     (flush),
        .is_div    (is_div),
        .is_signed (is_signed),
        .a         (rs_data),
        .b         (rt_data),
        .busy      (md_busy),
        .done_c    (done_c),
        .hi_c      (res_hi_c),
        .lo_c      (res_lo_c)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hi <= '0;
            lo <= '0;
        end else if (done_c && !flush) begin
            hi <= res_hi_c;
            lo <= res_lo_c;
        end
    end

endmodule

// File: doc/alu_ctrl_mdu.md
ALU_CTRL_MDU -- requirements
Module: alu_ctrl_mdu

Interface
REQ-001 SHALL have parameter WIDTH, default 32: datapath width; legal values are even and at least 8.
REQ-002 SHALL have port clk  in  1  sole clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n  in  1  reset, synchronous, active-low.
REQ-004 SHALL have port valid_in  in  1  an instruction is presented this cycle.
REQ-005 SHALL have port ALUOp  in  2  main-decoder ALU class.
REQ-006 SHALL have port Function  in  6  R-type funct field.
REQ-007 SHALL have port rs_data, rt_data  in  WIDTH each  operands (dividend/multiplicand = rs_data).
REQ-008 SHALL have port flush  in  1  abort the in-flight multiply/divide.
REQ-009 SHALL have port ALU_Control  out  4  ALU operation select, combinational.
REQ-010 SHALL have port md_busy  out  1  multiply/divide engine occupied.
REQ-011 SHALL have port stall  out  1  the pipeline must hold the presented instruction, combinational.
REQ-012 SHALL have port hilo_rdata  out  WIDTH  HI for mfhi, LO for mflo, 0 otherwise, combinational.

Function
REQ-013 SHALL decode ALU_Control combinationally, independent of valid_in:
- ALUOp=00 -> 0010.
- ALUOp=01 -> 0110.
- ALUOp=1x with funct 100100 -> 0000.
- ALUOp=11 with funct 001100 -> 0000.
- ALUOp=10 with funct 100101->0001, 100000->0010, 100010->0110, 100111->1100, 101010->0111, 100110->0100, 011000/011001->0101, 011010/011011->1011, 000000->1000, 000010->1001, 000011->1010.
- All other codes -> 0000.
REQ-014 SHALL treat ALUOp=10 with funct 011000/011001/011010/011011 as mult/multu/div/divu, and 010000/010010 as mfhi/mflo.
REQ-015 SHALL use FSM states IDLE, MUL, DIV, FIX.
- IDLE->MUL or IDLE->DIV when valid_in && op is mult* or div* && !stall; rs_data, rt_data and signedness are latched that edge.
REQ-016 SHALL iterate 1 bit per cycle in MUL/DIV (shift-add multiply; restoring divide on magnitudes) for exactly WIDTH cycles, then go to FIX.
REQ-017 SHALL in FIX apply sign correction:
- signed mult: negate the 2*WIDTH product if the operand signs differ.
- signed div: quotient negated if operand signs differ; remainder takes the dividend's sign.
- FIX writes HI/LO and returns to IDLE.
REQ-018 SHALL set md_busy high from the cycle after acceptance through the FIX cycle inclusive: WIDTH+1 cycles; new HI/LO visible the cycle after FIX.
REQ-019 SHALL assign HI/LO: mult -> HI = upper WIDTH bits, LO = lower WIDTH bits; div -> LO = quotient, HI = remainder.
REQ-020 SHALL handle divide-by-zero: LO = all ones, HI = rs_data; no exception; latency unchanged.
REQ-021 SHALL handle signed overflow (rs = -2^(WIDTH-1), rt = -1): LO = -2^(WIDTH-1), HI = 0.
REQ-022 SHALL assert stall when valid_in && md_busy && op is mult*, div*, mfhi or mflo; all other ops never stall.
REQ-023 SHALL on flush return to IDLE on the next edge, drop md_busy, and leave HI/LO unchanged.
- flush has priority over acceptance in the same cycle: a mult/div presented with flush is not accepted.
REQ-024 SHALL not bypass in-flight results: mfhi/mflo are serviced only when !md_busy, returning committed HI/LO.

Reset
REQ-025 SHALL on rst_n low at a clock edge:
- FSM -> IDLE; HI, LO, counter and working registers -> 0; md_busy -> 0.
- An in-flight operation is discarded.
REQ-026 SHALL drive stall and hilo_rdata from reset-state registers: stall 0; hilo_rdata 0 for mfhi/mflo.

Structure
REQ-027 SHALL place the following in shared package mips_pkg, also used by the existing ALU and main decoder:
- ALU_Control encodings (4-bit constants).
- funct codes.
- ALUOp encodings.
- md_state_t enum.
REQ-028 SHALL implement the iterative engine as one sub-module, mdu_iter (WIDTH-parametrised, start/flush/done handshake); decode, stall and HI/LO registers stay in alu_ctrl_mdu.

Verification
REQ-029 SHALL cover decode sweep: every ALUOp/funct pair -> ALU_Control matches REQ-013; e.g. 10/101010 -> 0111, 11/001100 -> 0000, 10/111111 -> 0000.
REQ-030 SHALL cover signed multiply (WIDTH=32): mult rs=-3, rt=7 -> md_busy 33 cycles; HI=FFFFFFFF, LO=FFFFFFEB; then mflo -> hilo_rdata=FFFFFFEB.
REQ-031 SHALL cover signed divide: div rs=-7, rt=2 -> LO=FFFFFFFD, HI=FFFFFFFF; divu rs=7, rt=0 -> LO=FFFFFFFF, HI=00000007.
REQ-032 SHALL cover hazard: mflo issued 1 cycle after multu 0xFFFFFFFF*2 -> stall held 33 cycles; then hilo_rdata=FFFFFFFE, HI=00000001.
REQ-033 SHALL cover abort: flush at busy cycle 10 of div, then rst_n low mid-mult -> HI/LO keep prior values after flush; HI=LO=0 after reset; md_busy 0 next cycle in both cases.
REQ-034 SHALL cover signed overflow (WIDTH=8): div 0x80 / 0xFF -> LO=80, HI=00, md_busy 9 cycles.
